// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG entropy-decode input path: marker/stuffing
// byte constants and the unpacker FSM state encoding.
package jpeg_pkg;

   localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
   localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;
   localparam logic [7:0] JPEG_RST0          = 8'hD0;
   localparam logic [7:0] JPEG_EOI           = 8'hD9;

   typedef enum logic [1:0] {
      ST_NORMAL = 2'd0,
      ST_GOT_FF = 2'd1,
      ST_MARKER = 2'd2
   } unpack_state_t;

endpackage

// File: rtl/jpeg_bit_buffer.sv
// Left-aligned bit shift buffer with a bit-count register. It supports a byte
// append, a left shift (consume) in the same cycle, and a full flush.
module jpeg_bit_buffer
   import jpeg_pkg::*;
#(
   parameter int BUF_W  = 32,
   parameter int PEEK_W = 16,
   parameter int CNT_W  = $clog2(BUF_W + 1)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              append_en,
   input  logic [7:0]        append_byte,
   input  logic [4:0]        shift_len,
   input  logic              flush,
   output logic [PEEK_W-1:0] peek_bits,
   output logic [CNT_W-1:0]  bits_avail
);

   logic [BUF_W-1:0] buf_q, buf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] base;

   // Bits past the count are always zero, so a shifted-in byte can be OR-ed
   // into place at the post-consume boundary.
   always_comb begin
      base  = cnt_q - CNT_W'(shift_len);
      buf_d = buf_q << shift_len;
      cnt_d = base;
      if (append_en) begin
         buf_d = buf_d | ({append_byte, {(BUF_W-8){1'b0}}} >> base);
         cnt_d = base + CNT_W'(8);
      end
      if (flush) begin
         buf_d = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         buf_q <= '0;
         cnt_q <= '0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
      end
   end

   assign peek_bits  = buf_q[BUF_W-1 -: PEEK_W];
   assign bits_avail = cnt_q;

endmodule

// File: rtl/jpeg_bitstream_unpacker.sv
// JPEG entropy-coded byte stream unpacker: removes FF00 stuffing, stalls on
// markers and serves a 16-bit peek window. Optional JPEG_ALIGN_EN adds align_req.
module jpeg_bitstream_unpacker
   import jpeg_pkg::*;
#(
   parameter int BUF_W  = 32,
   parameter int PEEK_W = 16
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         in_valid,
   input  logic [7:0]                   in_byte,
   output logic                         in_ready,
   output logic [PEEK_W-1:0]            peek_bits,
   output logic [$clog2(BUF_W+1)-1:0]   bits_avail,
   input  logic                         consume_valid,
   input  logic [4:0]                   consume_len,
   output logic                         consume_err,
   output logic                         marker_valid,
   output logic [7:0]                   marker_code,
   input  logic                         marker_clear,
`ifdef JPEG_ALIGN_EN
   input  logic                         align_req,
`endif
   output unpack_state_t                dbg_state
);

   localparam int CNT_W = $clog2(BUF_W + 1);

   unpack_state_t state_q, state_d;
   logic [7:0]    marker_code_q;
   logic          consume_err_q;

   logic       accept;
   logic       append_en;
   logic [7:0] append_byte;
   logic       code_load;
   logic       flush;
   logic       len_ok;
   logic       consume_ok;
   logic       consume_bad;
   logic [4:0] shift_len;

   // Input handshake: a byte transfers on a rising edge where in_valid and
   // in_ready are both high; in_ready depends on registered state only.
   assign in_ready = (state_q != ST_MARKER) && (bits_avail <= CNT_W'(BUF_W - 8));
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      append_en   = 1'b0;
      append_byte = in_byte;
      code_load   = 1'b0;
      flush       = 1'b0;
      case (state_q)
         ST_NORMAL: begin
            if (accept) begin
               if (in_byte == JPEG_MARKER_PREFIX) state_d = ST_GOT_FF;
               else append_en = 1'b1;
            end
         end
         ST_GOT_FF: begin
            if (accept) begin
               if (in_byte == JPEG_STUFF_BYTE) begin
                  append_en   = 1'b1;
                  append_byte = JPEG_MARKER_PREFIX;
                  state_d     = ST_NORMAL;
               end else if (in_byte != JPEG_MARKER_PREFIX) begin
                  code_load = 1'b1;
                  state_d   = ST_MARKER;
               end
            end
         end
         ST_MARKER: begin
            if (marker_clear) begin
               flush   = 1'b1;
               state_d = ST_NORMAL;
            end
         end
         default: state_d = ST_NORMAL;
      endcase
   end

   // A marker flush discards the buffer, so any consume in that cycle is moot.
   always_comb begin
      len_ok      = (consume_len != 5'd0) && (CNT_W'(consume_len) <= bits_avail);
      consume_ok  = consume_valid && !flush && len_ok;
      consume_bad = consume_valid && !flush && !len_ok;
      shift_len   = consume_ok ? consume_len : 5'd0;
`ifdef JPEG_ALIGN_EN
      if (align_req && !consume_valid && !flush)
         shift_len = {2'b00, bits_avail[2:0]};
`endif
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_NORMAL;
         marker_code_q <= 8'h00;
         consume_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (code_load)   marker_code_q <= in_byte;
         if (consume_bad) consume_err_q <= 1'b1;
      end
   end

   jpeg_bit_buffer #(
      .BUF_W  (BUF_W),
      .PEEK_W (PEEK_W),
      .CNT_W  (CNT_W)
   ) u_bit_buffer (
      .clock       (clock),
      .reset_n     (reset_n),
      .append_en   (append_en),
      .append_byte (append_byte),
      .shift_len   (shift_len),
      .flush       (flush),
      .peek_bits   (peek_bits),
      .bits_avail  (bits_avail)
   );

   assign marker_valid = (state_q == ST_MARKER);
   assign marker_code  = marker_code_q;
   assign consume_err  = consume_err_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_jpeg_bitstream_unpacker.sv
// Self-checking bench for jpeg_bitstream_unpacker; a bit-level queue holds the
// expected unstuffed stream. Define JPEG_ALIGN_EN to exercise align_req.
module tb_jpeg_bitstream_unpacker;
   import jpeg_pkg::*;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_byte = 8'h00;
   logic          in_ready;
   logic [15:0]   peek_bits;
   logic [5:0]    bits_avail;
   logic          consume_valid = 1'b0;
   logic [4:0]    consume_len = 5'd0;
   logic          consume_err;
   logic          marker_valid;
   logic [7:0]    marker_code;
   logic          marker_clear = 1'b0;
`ifdef JPEG_ALIGN_EN
   logic          align_req = 1'b0;
`endif
   unpack_state_t dbg_state;

   int checks = 0;
   int errors = 0;
   logic [0:0] exp_q[$];

   always #5 clock = ~clock;

   jpeg_bitstream_unpacker dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_byte       (in_byte),
      .in_ready      (in_ready),
      .peek_bits     (peek_bits),
      .bits_avail    (bits_avail),
      .consume_valid (consume_valid),
      .consume_len   (consume_len),
      .consume_err   (consume_err),
      .marker_valid  (marker_valid),
      .marker_code   (marker_code),
      .marker_clear  (marker_clear),
`ifdef JPEG_ALIGN_EN
      .align_req     (align_req),
`endif
      .dbg_state     (dbg_state)
   );

   // ---------------- clock / reset ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      in_valid = 1'b0;
      consume_valid = 1'b0;
      marker_clear = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      exp_q.delete();
   endtask

   // ---------------- scoreboard model ----------------
   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
   endtask

   task automatic pop_bits(input int n);
      for (int i = 0; i < n; i++) void'(exp_q.pop_front());
   endtask

   function automatic logic [15:0] model_peek();
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 16; i++)
         if (i < exp_q.size()) r[15-i] = exp_q[i];
      return r;
   endfunction

   // ---------------- drivers ----------------
   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_byte = b;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (in_ready) ok = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: byte %h never accepted, in_ready=%b", b, in_ready);
      end
   endtask

   // Drives one consume cycle; the model drops bits only when the request is legal.
   task automatic consume(input int n);
      consume_valid = 1'b1;
      consume_len = 5'(n);
      tick();
      consume_valid = 1'b0;
      consume_len = 5'd0;
      if (n > 0 && n <= exp_q.size()) pop_bits(n);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++;
      if ({peek_bits, bits_avail, in_ready, marker_valid, marker_code, consume_err}
          !== {16'h0000, 6'd0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: peek=%h avail=%0d rdy=%b mv=%b mc=%h err=%b", peek_bits,
                  bits_avail, in_ready, marker_valid, marker_code, consume_err);
      end
   endtask

   task automatic test_basic();
      push_byte(8'hA5); send_byte(8'hA5);
      push_byte(8'h3C); send_byte(8'h3C);
      checks++;
      if (bits_avail !== 6'd16) begin
         errors++; $display("FAIL basic_avail16: got %0d expected 16", bits_avail);
      end
      consume(4);
      checks++;
      if (bits_avail !== 6'd12) begin
         errors++; $display("FAIL basic_avail12: got %0d expected 12", bits_avail);
      end
      checks++;
      if (peek_bits !== 16'h53C0) begin
         errors++; $display("FAIL basic_peek: got %h expected 53c0", peek_bits);
      end
      consume(12);
      checks++;
      if (bits_avail !== 6'(exp_q.size()) || peek_bits !== model_peek()) begin
         errors++; $display("FAIL basic_drain: avail %0d peek %h expected %0d %h",
                            bits_avail, peek_bits, exp_q.size(), model_peek());
      end
   endtask

   task automatic test_stuffing();
      push_byte(8'h12); send_byte(8'h12);
      send_byte(8'hFF);
      checks++;
      if (bits_avail !== 6'd8) begin
         errors++; $display("FAIL stuff_ff_held: got %0d expected 8", bits_avail);
      end
      push_byte(8'hFF); send_byte(8'h00);
      checks++;
      if (bits_avail !== 6'd16) begin
         errors++; $display("FAIL stuff_ff_appended: got %0d expected 16", bits_avail);
      end
      push_byte(8'h34); send_byte(8'h34);
      checks++;
      if (bits_avail !== 6'd24 || peek_bits !== 16'h12FF) begin
         errors++; $display("FAIL stuff_peek: avail %0d peek %h expected 24 12ff",
                            bits_avail, peek_bits);
      end
      consume(16);
      checks++;
      if (peek_bits !== 16'h3400 || peek_bits !== model_peek()) begin
         errors++; $display("FAIL stuff_next_byte: got %h expected 3400", peek_bits);
      end
      consume(8);
   endtask

   task automatic test_marker();
      push_byte(8'hB8); send_byte(8'hB8);
      consume(3);
      send_byte(8'hFF);
      send_byte(8'hFF);
      send_byte(8'hD3);
      checks++;
      if (marker_valid !== 1'b1 || marker_code !== 8'hD3 || dbg_state !== ST_MARKER) begin
         errors++; $display("FAIL marker_detect: mv %b code %h state %0d expected 1 d3 %0d",
                            marker_valid, marker_code, dbg_state, ST_MARKER);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL marker_stall: in_ready %b expected 0", in_ready);
      end
      checks++;
      if (bits_avail !== 6'd5 || peek_bits !== model_peek()) begin
         errors++; $display("FAIL marker_bits_kept: avail %0d peek %h expected 5 %h",
                            bits_avail, peek_bits, model_peek());
      end
      marker_clear = 1'b1;
      consume_valid = 1'b1;
      consume_len = 5'd2;
      tick();
      marker_clear = 1'b0;
      consume_valid = 1'b0;
      consume_len = 5'd0;
      exp_q.delete();
      checks++;
      if (bits_avail !== 6'd0 || peek_bits !== 16'h0000 || in_ready !== 1'b1) begin
         errors++; $display("FAIL marker_flush: avail %0d peek %h rdy %b expected 0 0000 1",
                            bits_avail, peek_bits, in_ready);
      end
      checks++;
      if (marker_valid !== 1'b0 || consume_err !== 1'b0) begin
         errors++; $display("FAIL marker_clear_flags: mv %b err %b expected 0 0",
                            marker_valid, consume_err);
      end
   endtask

   task automatic test_full_and_concurrent();
      logic [7:0] b;
      int n;
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom_range(0, 254));
         push_byte(b);
         send_byte(b);
      end
      checks++;
      if (bits_avail !== 6'd32 || in_ready !== 1'b0) begin
         errors++; $display("FAIL full_stall: avail %0d rdy %b expected 32 0", bits_avail, in_ready);
      end
      consume(8);
      checks++;
      if (bits_avail !== 6'd24 || in_ready !== 1'b1) begin
         errors++; $display("FAIL full_resume: avail %0d rdy %b expected 24 1", bits_avail, in_ready);
      end
      b = 8'($urandom_range(0, 254));
      in_valid = 1'b1;
      in_byte = b;
      consume_valid = 1'b1;
      consume_len = 5'd3;
      tick();
      in_valid = 1'b0;
      consume_valid = 1'b0;
      consume_len = 5'd0;
      pop_bits(3);
      push_byte(b);
      checks++;
      if (bits_avail !== 6'd29 || peek_bits !== model_peek()) begin
         errors++; $display("FAIL concurrent: avail %0d peek %h expected 29 %h",
                            bits_avail, peek_bits, model_peek());
      end
      while (exp_q.size() > 0) begin
         n = $urandom_range(1, 16);
         if (n > exp_q.size()) n = exp_q.size();
         checks++;
         if (peek_bits !== model_peek() || bits_avail !== 6'(exp_q.size())) begin
            errors++; $display("FAIL drain_order: peek %h avail %0d expected %h %0d",
                               peek_bits, bits_avail, model_peek(), exp_q.size());
         end
         consume(n);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] raw[$];
      logic [7:0] push_val[$];
      bit         push_en[$];
      logic [7:0] d;
      int idx, cyc, len, lim;
      bit acc;
      for (int i = 0; i < 24; i++) begin
         d = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
         if (d == 8'hFF) begin
            raw.push_back(8'hFF); push_en.push_back(1'b0); push_val.push_back(8'h00);
            raw.push_back(8'h00); push_en.push_back(1'b1); push_val.push_back(8'hFF);
         end else begin
            raw.push_back(d); push_en.push_back(1'b1); push_val.push_back(d);
         end
      end
      idx = 0;
      cyc = 0;
      while ((idx < raw.size() || exp_q.size() > 0) && cyc < 400) begin
         checks++;
         if (peek_bits !== model_peek() || bits_avail !== 6'(exp_q.size())) begin
            errors++; $display("FAIL b2b_stream: cyc %0d peek %h avail %0d expected %h %0d",
                               cyc, peek_bits, bits_avail, model_peek(), exp_q.size());
         end
         checks++;
         if (in_ready !== (exp_q.size() <= 24)) begin
            errors++; $display("FAIL b2b_ready: cyc %0d got %b expected %b", cyc, in_ready,
                               exp_q.size() <= 24);
         end
         in_valid = (idx < raw.size());
         in_byte = (idx < raw.size()) ? raw[idx] : 8'h00;
         len = 0;
         if (exp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            lim = (exp_q.size() < 16) ? exp_q.size() : 16;
            len = $urandom_range(1, lim);
         end
         consume_valid = (len != 0);
         consume_len = 5'(len);
         acc = in_valid && in_ready;
         tick();
         pop_bits(len);
         if (acc) begin
            if (push_en[idx]) push_byte(push_val[idx]);
            idx++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      consume_valid = 1'b0;
      consume_len = 5'd0;
      if (cyc >= 400) begin
         checks++;
         errors++;
         $display("FAIL b2b_timeout: %0d of %0d bytes sent, %0d bits left", idx, raw.size(),
                  exp_q.size());
      end
   endtask

   task automatic test_consume_err();
      push_byte(8'h9E); send_byte(8'h9E);
      consume(3);
      consume(6);
      checks++;
      if (bits_avail !== 6'd5 || peek_bits !== model_peek()) begin
         errors++; $display("FAIL err_no_change: avail %0d peek %h expected 5 %h",
                            bits_avail, peek_bits, model_peek());
      end
      checks++;
      if (consume_err !== 1'b1) begin
         errors++; $display("FAIL err_set: got %b expected 1", consume_err);
      end
      consume(2);
      checks++;
      if (consume_err !== 1'b1 || bits_avail !== 6'd3) begin
         errors++; $display("FAIL err_sticky: err %b avail %0d expected 1 3",
                            consume_err, bits_avail);
      end
      push_byte(8'h11); send_byte(8'h11);
      #2;
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      checks++;
      if ({peek_bits, bits_avail, in_ready, marker_valid, marker_code, consume_err}
          !== {16'h0000, 6'd0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: peek=%h avail=%0d rdy=%b mv=%b mc=%h err=%b", peek_bits,
                  bits_avail, in_ready, marker_valid, marker_code, consume_err);
      end
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
   endtask

`ifdef JPEG_ALIGN_EN
   task automatic test_align();
      apply_reset();
      push_byte(8'h5A); send_byte(8'h5A);
      push_byte(8'hC3); send_byte(8'hC3);
      consume(3);
      align_req = 1'b1;
      tick();
      align_req = 1'b0;
      pop_bits(5);
      checks++;
      if (bits_avail !== 6'd8 || peek_bits !== 16'hC300 || peek_bits !== model_peek()) begin
         errors++; $display("FAIL align: avail %0d peek %h expected 8 c300", bits_avail, peek_bits);
      end
      align_req = 1'b1;
      consume(2);
      align_req = 1'b0;
      checks++;
      if (bits_avail !== 6'd6 || peek_bits !== model_peek()) begin
         errors++; $display("FAIL align_vs_consume: avail %0d peek %h expected 6 %h",
                            bits_avail, peek_bits, model_peek());
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      apply_reset();
      test_reset();
      test_basic();
      test_stuffing();
      test_marker();
      test_full_and_concurrent();
      test_back_to_back();
      test_consume_err();
`ifdef JPEG_ALIGN_EN
      test_align();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/jpeg_bitstream_unpacker.md
# jpeg_bitstream_unpacker

Input stage of the JPEG Huffman decode path, the receive-side counterpart of the Huffman encode controller. It accepts the entropy-coded byte stream (8-bit bytes, MSB first), removes `0xFF 0x00` byte stuffing and detects markers. It holds the unstuffed bits in a 32-bit shift buffer and presents a 16-bit MSB-aligned peek window, which the downstream Huffman/VLI decoder consumes 1–16 bits at a time.

## Interface
- `BUF_W`, 32: bit-buffer width; fixed legal value 32.
- `PEEK_W`, 16: peek window width; equal to the maximum consume length.

- `clock`  in  1: sole clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_byte` valid.
- `in_byte`  in  8: next stream byte.
- `in_ready`  out  1: byte accepted when `in_valid & in_ready`.
- `peek_bits`  out  16: next 16 unconsumed bits, MSB = oldest; positions ≥ `bits_avail` read 0.
- `bits_avail`  out  6: unconsumed bit count, 0..32.
- `consume_valid`  in  1: consume request.
- `consume_len`  in  5: bits to consume, 1..16.
- `consume_err`  out  1: sticky; set by an illegal consume.
- `marker_valid`  out  1: marker detected; input stalled.
- `marker_code`  out  8: the byte following `0xFF` (e.g. `0xD0`–`0xD7`, `0xD9`).
- `marker_clear`  in  1: acknowledge the marker and resume.
- `align_req`  in  1: only with `JPEG_ALIGN_EN`; discard bits up to the next byte boundary.

## Operation
- FSM states:
  - NORMAL: data byte ≠ `0xFF` → append 8 bits. `0xFF` → GOT_FF, nothing appended.
  - GOT_FF: `0x00` → append `0xFF`, back to NORMAL. `0xFF` → stay in GOT_FF (fill byte, dropped). Other value → MARKER, latch `marker_code`, assert `marker_valid`.
  - MARKER: `in_ready`=0. Bits already buffered stay consumable. On `marker_clear`: flush the buffer (`bits_avail`←0, remaining bits are pad), drop `marker_valid`, go to NORMAL.
- `in_ready` = (state ≠ MARKER) & (`bits_avail` ≤ 24), using the registered count.
- Buffer is left-aligned; appended bytes go to bit position `bits_avail`.
- `bits_avail` is always a multiple of 8 minus consumed bits, so `bits_avail[2:0]` equals the bit offset to the next byte boundary.
- Consume is legal when `consume_len` ≤ `bits_avail` and `consume_len` ≠ 0. The buffer shifts left by `consume_len`.
- Illegal consume: ignored, and `consume_err` is set. It stays set until reset.
- Same cycle consume + append:
  - New count = old − len + 8.
  - The byte is placed at position (old − len).
  - Never overflows, because append requires old ≤ 24.
- `marker_clear` outside MARKER is ignored. `marker_clear` together with `consume_valid`: the flush wins and the consume is dropped without error.
- Reset: state NORMAL, buffer 0, `bits_avail`=0, `peek_bits`=0, `in_ready`=1, `marker_valid`=0, `marker_code`=0, `consume_err`=0. Reset mid-stream discards everything immediately (asynchronous).

## Timing
- Accepted byte is visible in `peek_bits`/`bits_avail` on the next cycle.
- A stuffed `0xFF` appears one cycle after the `0x00` is accepted.
- Consume takes effect on the next edge. `peek_bits` and `bits_avail` are registered, or derived combinationally from registered state only.
- `marker_valid` rises the cycle after the marker byte is accepted.
- `in_ready` returns the cycle after `marker_clear`.
- Sustained throughput: 8 bits/cycle in and up to 16 bits/cycle out. Back-to-back consumes are allowed every cycle.

## Configuration
- `JPEG_ALIGN_EN` defined:
  - `align_req` port exists.
  - On `align_req`, discard `bits_avail[2:0]` bits. No-op when already aligned.
  - `align_req` with `consume_valid` in the same cycle: the consume wins and the align is ignored.
  - Align with append in the same cycle is legal.
- Not defined: port absent; alignment happens only through the marker flush.

## Structure
- Shared package `jpeg_pkg`:
  - Constants: `JPEG_MARKER_PREFIX`=8'hFF, `JPEG_STUFF_BYTE`=8'h00, `JPEG_RST0`=8'hD0, `JPEG_EOI`=8'hD9.
  - FSM state encoding enum `unpack_state_t`.
- One sub-module, `jpeg_bit_buffer`: 32-bit left-aligned shift buffer with append/consume/flush and the count register. The FSM and stuffing logic stay in the top.

## Test plan
- Bytes `0xA5,0x3C`, then consume 4 → `bits_avail`=12, `peek_bits`=16'h53C0.
- Bytes `0x12,0xFF,0x00,0x34` → 24 bits, `peek_bits`=16'h12FF; next 8 bits = `0x34`.
- Bytes `0xFF,0xFF,0xD3` after 5 buffered bits → `marker_valid`=1, `marker_code`=0xD3, `in_ready`=0, `bits_avail`=5. `marker_clear` → `bits_avail`=0, `in_ready`=1.
- Fill to 32 bits: `in_ready`=0. Consume 8 → `in_ready`=1. Consume 3 and append in the same cycle → count 24−3+8 = 29, bit order intact.
- `bits_avail`=5 and consume 6 → no change, `consume_err`=1. Reset mid-stream → all outputs at their reset values.
- With `JPEG_ALIGN_EN`: `bits_avail`=13, `align_req` → `bits_avail`=8, `peek_bits` = the next whole byte.
